// File: rtl/autoc_window_sum_if.sv
// Sample/result bundle between the delay-multiply stage and the sliding-window accumulator.
// The master drives samples and control; the slave returns the window sum and detect.
interface autoc_window_sum_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 37
);
  logic                        clear;
  logic                        strobe_in;
  logic signed [IN_WIDTH-1:0]  data_in;
  logic signed [OUT_WIDTH-1:0] threshold;
  logic signed [OUT_WIDTH-1:0] sum_out;
  logic                        strobe_out;
  logic                        window_full;
  logic                        detect;

  modport master (
    output clear, strobe_in, data_in, threshold,
    input  sum_out, strobe_out, window_full, detect
  );

  modport slave (
    input  clear, strobe_in, data_in, threshold,
    output sum_out, strobe_out, window_full, detect
  );
endinterface

// File: rtl/autoc_window_sum.sv
// Running sum of the last 2^WINDOW_LOG2 signed lag products, kept in a circular buffer,
// with a level-sensitive threshold detector that holds off for HOLDOFF output strobes.
module autoc_window_sum #(
  parameter int IN_WIDTH    = 32,
  parameter int WINDOW_LOG2 = 5,
  parameter int HOLDOFF     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  autoc_window_sum_if.slave bus
);
  localparam int OUT_WIDTH = IN_WIDTH + WINDOW_LOG2;
  localparam int W         = 1 << WINDOW_LOG2;
  localparam int HO_W      = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [WINDOW_LOG2:0] FILL_MAX  = (WINDOW_LOG2 + 1)'(W);
  localparam logic [HO_W-1:0]      HO_LOAD   = HO_W'(HOLDOFF);
  localparam logic                 HO_ENTERS = (HOLDOFF != 0);

  typedef enum logic {
    S_ARMED,
    S_HOLDOFF
  } state_t;

  function automatic logic signed [OUT_WIDTH-1:0] sext(input logic signed [IN_WIDTH-1:0] x);
    return {{WINDOW_LOG2{x[IN_WIDTH-1]}}, x};
  endfunction

  logic signed [IN_WIDTH-1:0]  mem [W];
  logic [WINDOW_LOG2-1:0]      wr_ptr;
  logic [WINDOW_LOG2:0]        fill;
  logic signed [OUT_WIDTH-1:0] sum_p1;
  logic                        vld_p1;
  logic                        det_p1;

  state_t                      state, state_nxt;
  logic [HO_W-1:0]             ho_cnt, ho_nxt;
  logic                        det_nxt;

  logic                        kill;
  logic                        take_p0;
  logic                        full_p0;
  logic signed [IN_WIDTH-1:0]  oldest_p0;
  logic signed [OUT_WIDTH-1:0] sum_nxt_p0;
  logic [WINDOW_LOG2:0]        fill_nxt_p0;
  logic                        full_nxt_p0;
  logic                        above_p0;

  // ---- stage p0: combinational update from the incoming sample ----
  assign kill    = !rst_n || bus.clear;
  assign take_p0 = bus.strobe_in && !kill;
  assign full_p0 = (fill == FILL_MAX);

  // Until the window has filled, the slot being overwritten holds stale RAM content.
  assign oldest_p0   = full_p0 ? mem[wr_ptr] : '0;
  assign sum_nxt_p0  = sum_p1 + sext(bus.data_in) - sext(oldest_p0);
  assign fill_nxt_p0 = full_p0 ? fill : fill + 1'b1;
  assign full_nxt_p0 = (fill_nxt_p0 == FILL_MAX);
  assign above_p0    = full_nxt_p0 && (sum_nxt_p0 > bus.threshold);

  always_ff @(posedge clk) begin
    if (take_p0) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_comb begin
    state_nxt = state;
    ho_nxt    = ho_cnt;
    det_nxt   = 1'b0;
    if (take_p0) begin
      case (state)
        S_ARMED: begin
          if (above_p0) begin
            det_nxt = 1'b1;
            ho_nxt  = HO_LOAD;
            if (HO_ENTERS) begin
              state_nxt = S_HOLDOFF;
            end
          end
        end
        S_HOLDOFF: begin
          ho_nxt = (ho_cnt != '0) ? ho_cnt - 1'b1 : '0;
          if (ho_cnt <= HO_W'(1)) begin
            state_nxt = S_ARMED;
          end
        end
        default: begin
          state_nxt = S_ARMED;
          ho_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      state  <= S_ARMED;
      ho_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ho_cnt <= ho_nxt;
    end
  end

  // ---- stage p1: registered window state and outputs ----
  always_ff @(posedge clk) begin
    if (kill) begin
      wr_ptr <= '0;
      fill   <= '0;
      sum_p1 <= '0;
      vld_p1 <= 1'b0;
      det_p1 <= 1'b0;
    end else begin
      vld_p1 <= take_p0;
      det_p1 <= det_nxt;
      if (take_p0) begin
        wr_ptr <= wr_ptr + 1'b1;
        fill   <= fill_nxt_p0;
        sum_p1 <= sum_nxt_p0;
      end
    end
  end

  assign bus.sum_out     = sum_p1;
  assign bus.strobe_out  = vld_p1;
  assign bus.window_full = (fill == FILL_MAX);
  assign bus.detect      = det_p1;
endmodule

// File: tb/tb_autoc_window_sum.sv
// Bench for autoc_window_sum: vector table, detect/clear/reset sequences and random traffic
// checked every cycle against a queue-based model of the last 32 samples.
module tb_autoc_window_sum;
  localparam int IN_WIDTH    = 32;
  localparam int WINDOW_LOG2 = 5;
  localparam int OUT_WIDTH   = 37;
  localparam int W           = 32;
  localparam int HOLDOFF     = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  autoc_window_sum_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();
  autoc_window_sum_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus0 ();

  assign bus0.clear     = bus.clear;
  assign bus0.strobe_in = bus.strobe_in;
  assign bus0.data_in   = bus.data_in;
  assign bus0.threshold = bus.threshold;

  autoc_window_sum #(.IN_WIDTH(IN_WIDTH), .WINDOW_LOG2(WINDOW_LOG2), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  autoc_window_sum #(.IN_WIDTH(IN_WIDTH), .WINDOW_LOG2(WINDOW_LOG2), .HOLDOFF(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  typedef struct {
    logic   stb;
    logic   clr;
    longint data;
    longint exp_sum;
    logic   exp_full;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: window contents, running sum, remaining hold-off strobes.
  longint q[$];
  longint m_sum = 0;
  int     ho_left = 0;
  logic   m_stb = 1'b0, m_full = 1'b0, m_det = 1'b0, m_det0 = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic stb, input longint d, input longint thr,
                              input logic clr, input logic rn);
    logic above;
    m_stb  = 1'b0;
    m_det  = 1'b0;
    m_det0 = 1'b0;
    if (!rn || clr) begin
      q.delete();
      m_sum   = 0;
      ho_left = 0;
    end else if (stb) begin
      q.push_back(longint'($signed(d[31:0])));
      if (q.size() > W) void'(q.pop_front());
      m_sum = 0;
      foreach (q[i]) m_sum += q[i];
      m_stb = 1'b1;
      above = (q.size() == W) && (m_sum > thr);
      if (ho_left > 0) ho_left--;
      else if (above) begin
        m_det   = 1'b1;
        ho_left = HOLDOFF;
      end
      m_det0 = above;
    end
    m_full = (q.size() == W);
  endtask

  task automatic step(input logic stb, input longint d, input longint thr,
                      input logic clr, input logic rn);
    @(negedge clk);
    bus.strobe_in = stb;
    bus.data_in   = d[31:0];
    bus.threshold = thr[36:0];
    bus.clear     = clr;
    rst_n         = rn;
    @(posedge clk);
    #1;
    model_update(stb, d, thr, clr, rn);
    check("sum_out",     $signed(bus.sum_out), m_sum);
    check("strobe_out",  {63'd0, bus.strobe_out}, {63'd0, m_stb});
    check("window_full", {63'd0, bus.window_full}, {63'd0, m_full});
    check("detect",      {63'd0, bus.detect}, {63'd0, m_det});
    check("detect_ho0",  {63'd0, bus0.detect}, {63'd0, m_det0});
    check("sum_out_ho0", $signed(bus0.sum_out), m_sum);
  endtask

  initial begin
    vec_t   vt[$];
    vec_t   v;
    longint p31;
    longint thr_max;
    longint thr;
    int     gaps;

    p31     = 64'sd2147483648;
    thr_max = 64'sd68719476735;

    v = '{stb: 1'b0, clr: 1'b1, data: 0, exp_sum: 0, exp_full: 1'b0};
    vt.push_back(v);
    for (int i = 1; i <= 40; i++) begin
      v = '{stb: 1'b1, clr: 1'b0, data: 1, exp_sum: (i < W) ? i : W, exp_full: (i >= W)};
      vt.push_back(v);
    end
    v = '{stb: 1'b0, clr: 1'b0, data: 7, exp_sum: W, exp_full: 1'b1};
    vt.push_back(v);
    v = '{stb: 1'b0, clr: 1'b1, data: 0, exp_sum: 0, exp_full: 1'b0};
    vt.push_back(v);
    for (int k = 1; k <= W; k++) begin
      v = '{stb: 1'b1, clr: 1'b0, data: -p31, exp_sum: -longint'(k) * p31, exp_full: (k == W)};
      vt.push_back(v);
    end
    for (int k = 1; k <= W; k++) begin
      v = '{stb: 1'b1, clr: 1'b0, data: 0, exp_sum: -longint'(W - k) * p31, exp_full: 1'b1};
      vt.push_back(v);
    end

    rst_n         = 1'b0;
    bus.clear     = 1'b0;
    bus.strobe_in = 1'b0;
    bus.data_in   = '0;
    bus.threshold = '0;

    step(1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 9, 0, 1'b0, 1'b0);
    check("rst_sum",    $signed(bus.sum_out), 0);
    check("rst_strobe", {63'd0, bus.strobe_out}, 0);
    check("rst_full",   {63'd0, bus.window_full}, 0);
    check("rst_detect", {63'd0, bus.detect}, 0);

    foreach (vt[i]) begin
      step(vt[i].stb, vt[i].data, thr_max, vt[i].clr, 1'b1);
      check("tbl_sum",  $signed(bus.sum_out), vt[i].exp_sum);
      check("tbl_full", {63'd0, bus.window_full}, {63'd0, vt[i].exp_full});
    end

    step(1'b0, 0, 20, 1'b1, 1'b1);
    for (int i = 1; i <= 170; i++) begin
      step(1'b1, 1, 20, 1'b0, 1'b1);
      check("det_seq",  {63'd0, bus.detect}, {63'd0, (i == 32 || i == 97 || i == 162)});
      check("det0_seq", {63'd0, bus0.detect}, {63'd0, (i >= 32)});
    end

    step(1'b0, 0, 0, 1'b1, 1'b1);
    thr = 0;
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) thr = longint'($signed($urandom)) * 4;
      gaps = $urandom_range(0, 5);
      for (int g = 0; g < gaps; g++) step(1'b0, longint'($urandom), thr, 1'b0, 1'b1);
      step(1'b1, longint'($signed($urandom)), thr, 1'b0, 1'b1);
    end

    step(1'b0, 0, 20, 1'b1, 1'b1);
    for (int i = 1; i <= 40; i++) step(1'b1, 1, 20, 1'b0, 1'b1);
    step(1'b1, 1000, 20, 1'b1, 1'b1);
    check("clr_sum",    $signed(bus.sum_out), 0);
    check("clr_full",   {63'd0, bus.window_full}, 0);
    check("clr_strobe", {63'd0, bus.strobe_out}, 0);
    for (int i = 1; i <= W; i++) begin
      step(1'b1, 1, 20, 1'b0, 1'b1);
      check("refill_sum", $signed(bus.sum_out), i);
      check("refill_det", {63'd0, bus.detect}, {63'd0, (i == W)});
    end

    for (int i = 0; i < 5; i++) step(1'b1, 1, 20, 1'b0, 1'b1);
    step(1'b1, 5, 20, 1'b0, 1'b0);
    check("rst2_sum",    $signed(bus.sum_out), 0);
    check("rst2_strobe", {63'd0, bus.strobe_out}, 0);
    check("rst2_full",   {63'd0, bus.window_full}, 0);
    check("rst2_detect", {63'd0, bus.detect}, 0);
    for (int i = 1; i <= W; i++) begin
      step(1'b1, 1, 20, 1'b0, 1'b1);
      check("rst_refill_det", {63'd0, bus.detect}, {63'd0, (i == W)});
    end
    step(1'b0, 0, 20, 1'b0, 1'b1);
    check("gap_hold_sum", $signed(bus.sum_out), W);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
